// File: rtl/reg_bank.sv
// 32 x 32-bit register file: two combinational read ports, one synchronous write port.
// Optional same-cycle write-to-read forwarding is enabled by defining REG_BANK_BYPASS_EN.
module reg_bank #(
  parameter int unsigned SP_INDEX = 29,
  parameter logic [31:0] SP_RESET = 32'd227
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reg_write,
  input  logic [4:0]  write_reg,
  input  logic [31:0] write_data,
  input  logic [4:0]  read_reg1,
  input  logic [4:0]  read_reg2,
  output logic [31:0] read_data1,
  output logic [31:0] read_data2
);

  localparam logic [4:0] SP_IDX = 5'(SP_INDEX);

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];
  logic        wr_en;

  // Gating on reg_write first keeps an undriven write_reg from selecting a row.
  always_comb begin
    wr_en = 1'b0;
    if (reg_write) begin
      wr_en = (write_reg != 5'd0);
    end
  end

  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[write_reg] = write_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs_q         <= '{default: '0};
      regs_q[SP_IDX] <= SP_RESET;
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    read_data1 = '0;
    if (read_reg1 != 5'd0) begin
      read_data1 = regs_q[read_reg1];
`ifdef REG_BANK_BYPASS_EN
      if (!reset && wr_en && (read_reg1 == write_reg)) begin
        read_data1 = write_data;
      end
`endif
    end
  end

  always_comb begin
    read_data2 = '0;
    if (read_reg2 != 5'd0) begin
      read_data2 = regs_q[read_reg2];
`ifdef REG_BANK_BYPASS_EN
      if (!reset && wr_en && (read_reg2 == write_reg)) begin
        read_data2 = write_data;
      end
`endif
    end
  end

endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank against an array-based model of the register file.
module tb_reg_bank;

  localparam int unsigned SP  = 29;
  localparam logic [31:0] SPR = 32'd227;

`ifdef REG_BANK_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        reg_write = 1'b0;
  logic [4:0]  write_reg = '0;
  logic [31:0] write_data = '0;
  logic [4:0]  read_reg1 = '0;
  logic [4:0]  read_reg2 = '0;
  logic [31:0] read_data1;
  logic [31:0] read_data2;

  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;
  logic [31:0] model [32];

  reg_bank #(.SP_INDEX(SP), .SP_RESET(SPR)) dut (
    .clk(clk), .reset(reset), .reg_write(reg_write), .write_reg(write_reg),
    .write_data(write_data), .read_reg1(read_reg1), .read_reg2(read_reg2),
    .read_data1(read_data1), .read_data2(read_data2)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    model[SP] = SPR;
  endfunction

  // Value a read port should show given the current (pre-edge) inputs.
  function automatic logic [31:0] expect_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (BYPASS && !reset && reg_write && write_reg != 5'd0 && write_reg == idx)
      return write_data;
    return model[idx];
  endfunction

  // Model commit for one rising edge.
  function automatic void model_edge();
    if (!reset && reg_write && write_reg != 5'd0) model[write_reg] = write_data;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_write(input logic [4:0] idx, input logic [31:0] data);
    reg_write = 1'b1; write_reg = idx; write_data = data;
    tick();
    reg_write = 1'b0;
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    model_reset();
    read_reg1 = 5'd29; read_reg2 = 5'd5;
    #1;
    n_cmp++;
    if (read_data1 !== 32'd227) begin n_fail++; $display("FAIL reset_sp: got %h want %h", read_data1, 32'd227); end
    n_cmp++;
    if (read_data2 !== 32'd0) begin n_fail++; $display("FAIL reset_r5: got %h want %h", read_data2, 32'd0); end
    tick();
    reset = 1'b0;
    #1;
    for (int i = 0; i < 32; i += 2) begin
      read_reg1 = 5'(i); read_reg2 = 5'(i + 1);
      #1;
      n_cmp++;
      if (read_data1 !== model[i] || read_data2 !== model[i+1]) begin
        n_fail++;
        $display("FAIL reset_scan r%0d/r%0d: got %h/%h want %h/%h", i, i + 1,
                 read_data1, read_data2, model[i], model[i+1]);
      end
    end
  endtask

  task automatic test_write_read();
    do_write(5'd8, 32'hDEADBEEF);
    read_reg1 = 5'd8;
    #1;
    n_cmp++;
    if (read_data1 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_r8: got %h want %h", read_data1, 32'hDEADBEEF); end
    do_write(5'd31, 32'h00400008);
    do_write(5'd29, 32'h0000_1000);
    read_reg1 = 5'd31; read_reg2 = 5'd29;
    #1;
    n_cmp++;
    if (read_data1 !== 32'h00400008 || read_data2 !== 32'h0000_1000) begin
      n_fail++; $display("FAIL wr_r31_r29: got %h/%h want %h/%h", read_data1, read_data2, 32'h00400008, 32'h0000_1000);
    end
  endtask

  task automatic test_zero();
    reg_write = 1'b1; write_reg = 5'd0; write_data = 32'h12345678;
    read_reg1 = 5'd0; read_reg2 = 5'd0;
    #1;
    n_cmp++;
    if (read_data1 !== 32'd0 || read_data2 !== 32'd0) begin
      n_fail++; $display("FAIL zero_during: got %h/%h want 0/0", read_data1, read_data2);
    end
    tick();
    reg_write = 1'b0;
    #1;
    n_cmp++;
    if (read_data1 !== 32'd0 || read_data2 !== 32'd0) begin
      n_fail++; $display("FAIL zero_after: got %h/%h want 0/0", read_data1, read_data2);
    end
  endtask

  task automatic test_same_cycle();
    logic [31:0] want;
    do_write(5'd9, 32'd5);
    reg_write = 1'b1; write_reg = 5'd9; write_data = 32'd7; read_reg2 = 5'd9; read_reg1 = 5'd9;
    #1;
    want = BYPASS ? 32'd7 : 32'd5;
    n_cmp++;
    if (read_data2 !== want || read_data1 !== want) begin
      n_fail++; $display("FAIL same_cycle_pre: got %h/%h want %h", read_data1, read_data2, want);
    end
    tick();
    reg_write = 1'b0;
    #1;
    n_cmp++;
    if (read_data2 !== 32'd7) begin n_fail++; $display("FAIL same_cycle_post: got %h want %h", read_data2, 32'd7); end
  endtask

  task automatic test_reset_mid();
    reg_write = 1'b1; write_reg = 5'd31; write_data = 32'h00400008;
    tick();
    read_reg1 = 5'd31; read_reg2 = 5'd29;
    #1;
    n_cmp++;
    if (read_data1 !== 32'h00400008) begin n_fail++; $display("FAIL mid_pre_r31: got %h want %h", read_data1, 32'h00400008); end
    #1 reset = 1'b1;
    model_reset();
    #1;
    n_cmp++;
    if (read_data1 !== 32'd0 || read_data2 !== 32'd227) begin
      n_fail++; $display("FAIL mid_reset: got %h/%h want %h/%h", read_data1, read_data2, 32'd0, 32'd227);
    end
    read_reg2 = 5'd8;
    #1;
    n_cmp++;
    if (read_data2 !== 32'd0) begin n_fail++; $display("FAIL mid_reset_r8: got %h want 0", read_data2); end
    tick();
    reset = 1'b0; reg_write = 1'b0;
    #1;
    n_cmp++;
    if (read_data1 !== 32'd0) begin n_fail++; $display("FAIL mid_write_lost: got %h want 0", read_data1); end
    do_write(5'd12, 32'hA5A5_0012);
    read_reg1 = 5'd12;
    #1;
    n_cmp++;
    if (read_data1 !== 32'hA5A5_0012) begin n_fail++; $display("FAIL first_write: got %h want %h", read_data1, 32'hA5A5_0012); end
  endtask

  task automatic test_no_write();
    reg_write = 1'b0; write_reg = 5'd10; write_data = 32'd1;
    repeat (3) tick();
    write_reg = 'x; write_data = 'x;
    tick();
    write_reg = '0; write_data = '0;
    read_reg1 = 5'd10; read_reg2 = 5'd12;
    #1;
    n_cmp++;
    if (read_data1 !== 32'd0 || read_data2 !== 32'hA5A5_0012) begin
      n_fail++; $display("FAIL no_write: got %h/%h want %h/%h", read_data1, read_data2, 32'd0, 32'hA5A5_0012);
    end
  endtask

  task automatic test_random();
    int unsigned bad = 0;
    logic [31:0] e1, e2;
    for (int n = 0; n < 400; n++) begin
      reg_write  = ($urandom_range(0, 3) != 0);
      write_reg  = 5'($urandom_range(0, 31));
      write_data = $urandom;
      read_reg1  = ($urandom_range(0, 3) == 0) ? write_reg : 5'($urandom_range(0, 31));
      read_reg2  = ($urandom_range(0, 5) == 0) ? read_reg1 : 5'($urandom_range(0, 31));
      #1;
      e1 = expect_read(read_reg1);
      e2 = expect_read(read_reg2);
      n_cmp++;
      if (read_data1 !== e1 || read_data2 !== e2) begin
        n_fail++;
        if (bad < 8)
          $display("FAIL random[%0d] r%0d/r%0d: got %h/%h want %h/%h", n, read_reg1, read_reg2,
                   read_data1, read_data2, e1, e2);
        bad++;
      end
      tick();
    end
    reg_write = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_write_read();
    test_zero();
    test_same_cycle();
    test_reset_mid();
    test_no_write();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, want finish before 200000");
    $fatal(1);
  end

endmodule
